running_light_engine: RTL and testbench
=======================================

Name: running_light_engine

Overview:
- Parametrised successor of the LED running-light shifter: WIDTH-bit light register with selectable shift, rotate, bounce and parallel-load modes.
- Built-in step prescaler, so the pattern advances at a visible rate from the system clock.
- Sits between the board clock and the LED bank; can also serve as a generic serial-in shift register.

Parameters:
- WIDTH, 8, light register width; must be >= 2.
- DIV, 1, prescaler ratio: one step every DIV enabled cycles; must be >= 1.
- RST_VAL, 0, light value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  in  1  prescaler/step enable.
- mode  in  3  operating mode (see Behaviour).
- data_i  in  1  serial input bit for the shift modes.
- load_val  in  WIDTH  parallel load value.
- light  out  WIDTH  registered light pattern.
- step_o  out  1  registered one-cycle pulse; high for the cycle after each light update.
- dir_o  out  1  bounce direction: 0 = right (toward bit 0), 1 = left.

Behaviour:
- Reset: rst == 0 at a clk edge sets light = RST_VAL, prescaler = 0, step_o = 0, dir_o = 0. Reset overrides all inputs, including while a pattern is running.
- Prescaler:
  - Width is max(1, clog2(DIV)).
  - Increments only when en = 1.
  - When the count equals DIV-1, it wraps to 0 and generates a step.
  - DIV = 1 gives a step on every enabled cycle.
  - en = 0 freezes the count and suppresses steps.
- step_o: goes to 1 at the same edge that updates light, else 0. Mode 0 and mode 7 steps still pulse step_o.
- Mode 6 (LOAD):
  - Acts every cycle, independent of en and the prescaler.
  - Sets light = load_val, prescaler = 0, dir_o = 0, step_o = 0.
- Modes applied only on a step:
  - 0 HOLD: light unchanged.
  - 1 SHR: light = {data_i, light[W-1:1]}. This is the legacy running-light behaviour.
  - 2 SHL: light = {light[W-2:0], data_i}.
  - 3 ROR: light = {light[0], light[W-1:1]}.
  - 4 ROL: light = {light[W-2:0], light[W-1]}.
  - 5 BOUNCE, zero fill:
    - dir_o = 0 and light[0] = 1: set dir_o = 1, light = light << 1. Otherwise, with dir_o = 0: light = light >> 1.
    - dir_o = 1 and light[W-1] = 1: set dir_o = 0, light = light >> 1. Otherwise, with dir_o = 1: light = light << 1.
    - An all-zero pattern stays zero. dir_o still follows the rules above; with light = 0 it never changes.
  - 7: reserved, behaves as HOLD.
- dir_o changes only in BOUNCE, LOAD and reset.
- Changing mode between steps does not reset the prescaler; the new mode applies at the next step.
- Latency: one clock from the step or load decision to light.

Optional Feature:
- Macro: RUNNING_LIGHT_SOUT_EN.
- Defined:
  - Adds output port data_o (1 bit, registered, reset 0) for cascading engines.
  - On each step, data_o takes the bit leaving the register:
    - light[0] in modes 1 and 3, and in BOUNCE when shifting right;
    - light[W-1] in modes 2 and 4, and in BOUNCE when shifting left.
  - HOLD/reserved: data_o unchanged. LOAD: data_o = 0.
- Undefined: no data_o port; all other behaviour is identical.

Decomposition:
- Package running_light_pkg holds:
  - mode encodings: MODE_HOLD = 0, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_BOUNCE, MODE_LOAD = 6;
  - DIR_RIGHT = 0, DIR_LEFT = 1.
- One sub-module, step_prescaler:
  - parameter DIV; inputs clk, rst, en, clr; output tick;
  - contains the counter and wrap logic.
- The top level holds the light register, dir_o, step_o and the mode mux.

Test Plan:
- Reset: drive rst = 0 for 2 edges with en = 1, mode = 1, data_i = 1 → light = 0x00, step_o = 0, dir_o = 0. Release rst → first step gives 0x80.
- SHR (WIDTH = 8, DIV = 1): load 0x00, then mode 1, data_i = 1 for 3 cycles → light 0x80, 0xC0, 0xE0; step_o = 1 each cycle.
- ROL/ROR: load 0x81.
  - Mode 4 → 0x03, then 0x06.
  - Reload 0x81, mode 3 → 0xC0, then 0x60.
- BOUNCE: load 0x02, mode 5.
  - Expected sequence: 0x01 (dir 0), 0x02 (dir 1), 0x04, …, 0x80.
  - Then 0x40 with dir_o = 0.
  - A load of 0x00 stays 0x00.
- Prescaler (DIV = 4): load 0x01, mode 3, en = 1.
  - light becomes 0x80 on the 4th edge; step_o is high for exactly 1 cycle.
  - Dropping en for 2 cycles mid-count delays the next step by 2 edges.
- Load and reset mid-operation (DIV = 4, bounce running):
  - Mode 6 with load_val = 0xA5 at prescaler count 2 → light = 0xA5 at the next edge, prescaler = 0, dir_o = 0.
  - rst = 0 during mode 1 → RST_VAL at the next edge.
  - With RUNNING_LIGHT_SOUT_EN: SHR from 0x01 → data_o = 1 after the step.

Source files
------------

// File: rtl/running_light_pkg.sv
// Shared definitions for the running-light engine.
//   mode_e    : 3-bit operating mode encoding (matches the mode port)
//   DIR_*     : bounce direction encoding on dir_o
package running_light_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'd0,
        MODE_SHR    = 3'd1,
        MODE_SHL    = 3'd2,
        MODE_ROR    = 3'd3,
        MODE_ROL    = 3'd4,
        MODE_BOUNCE = 3'd5,
        MODE_LOAD   = 3'd6,
        MODE_RSVD   = 3'd7
    } mode_e;

    localparam logic DIR_RIGHT = 1'b0;  // toward bit 0
    localparam logic DIR_LEFT  = 1'b1;  // toward bit WIDTH-1

endpackage

// File: rtl/running_light_engine_step_prescaler.sv
// Step prescaler: emits one tick every DIV enabled cycles.
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset (count -> 0)
//   en   : count enable; when low the count freezes and no tick is produced
//   clr  : synchronous clear (parallel load restarts the step phase)
//   tick : combinational, high on the enabled cycle whose edge wraps the count
module step_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // With DIV == 1 the count is pinned at 0 and every enabled cycle ticks.
    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/running_light_engine.sv
// Running-light engine: WIDTH-bit light register with shift, rotate, bounce
// and parallel-load modes, advanced by a built-in step prescaler.
//   clk, rst       : clock (rising) and synchronous active-low reset
//   en             : prescaler/step enable
//   mode           : 0 HOLD, 1 SHR, 2 SHL, 3 ROR, 4 ROL, 5 BOUNCE, 6 LOAD, 7 HOLD
//   data_i         : serial fill bit for SHR/SHL
//   load_val       : parallel load value (LOAD acts every cycle, ignores en)
//   light          : registered light pattern
//   step_o         : one-cycle pulse in the cycle after each step update
//   dir_o          : bounce direction (0 right, 1 left)
//   data_o         : only with RUNNING_LIGHT_SOUT_EN defined; the bit shifted
//                    out on the last step, for cascading engines
module running_light_engine
    import running_light_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DIV     = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             data_i,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] light,
    output logic             step_o,
`ifdef RUNNING_LIGHT_SOUT_EN
    output logic             data_o,
`endif
    output logic             dir_o
);

    mode_e mode_s;
    logic  load;
    logic  tick;

    logic [WIDTH-1:0] light_q, light_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;

    assign mode_s = mode_e'(mode);
    assign load   = (mode_s == MODE_LOAD);

    step_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    always_comb begin
        light_d = light_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        if (load) begin
            light_d = load_val;
            dir_d   = DIR_RIGHT;
        end else if (tick) begin
            step_d = 1'b1;
            unique case (mode_s)
                MODE_SHR: light_d = {data_i, light_q[WIDTH-1:1]};
                MODE_SHL: light_d = {light_q[WIDTH-2:0], data_i};
                MODE_ROR: light_d = {light_q[0], light_q[WIDTH-1:1]};
                MODE_ROL: light_d = {light_q[WIDTH-2:0], light_q[WIDTH-1]};
                MODE_BOUNCE: begin
                    // Reverse when the lit end reaches the edge; an all-zero
                    // pattern never hits either edge so dir stays put.
                    if (dir_q == DIR_RIGHT) begin
                        if (light_q[0]) begin
                            dir_d   = DIR_LEFT;
                            light_d = light_q << 1;
                        end else begin
                            light_d = light_q >> 1;
                        end
                    end else begin
                        if (light_q[WIDTH-1]) begin
                            dir_d   = DIR_RIGHT;
                            light_d = light_q >> 1;
                        end else begin
                            light_d = light_q << 1;
                        end
                    end
                end
                default: light_d = light_q;  // HOLD and reserved
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            light_q <= RST_VAL;
            step_q  <= 1'b0;
            dir_q   <= DIR_RIGHT;
        end else begin
            light_q <= light_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
        end
    end

    assign light  = light_q;
    assign step_o = step_q;
    assign dir_o  = dir_q;

`ifdef RUNNING_LIGHT_SOUT_EN
    logic data_o_q, data_o_d;

    always_comb begin
        data_o_d = data_o_q;
        if (load) begin
            data_o_d = 1'b0;
        end else if (tick) begin
            unique case (mode_s)
                MODE_SHR, MODE_ROR: data_o_d = light_q[0];
                MODE_SHL, MODE_ROL: data_o_d = light_q[WIDTH-1];
                MODE_BOUNCE: begin
                    // Shifting left when bouncing off bit 0 or still heading left.
                    if ((dir_q == DIR_RIGHT && light_q[0]) ||
                        (dir_q == DIR_LEFT && !light_q[WIDTH-1]))
                        data_o_d = light_q[WIDTH-1];
                    else
                        data_o_d = light_q[0];
                end
                default: data_o_d = data_o_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) data_o_q <= 1'b0;
        else      data_o_q <= data_o_d;
    end

    assign data_o = data_o_q;
`endif

endmodule

// File: tb/tb_running_light_engine.sv
module tb_running_light_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic [2:0] mode = 3'd1;
    logic       data_i = 1'b1;
    logic [7:0] load_val = 8'h00;

    logic [7:0] light1, light4;
    logic       step1, step4, dir1, dir4;
    logic       dout1, dout4;

    always #5 clk = ~clk;

    running_light_engine #(.WIDTH(8), .DIV(1), .RST_VAL(8'h00)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .data_i(data_i),
        .load_val(load_val), .light(light1), .step_o(step1),
`ifdef RUNNING_LIGHT_SOUT_EN
        .data_o(dout1),
`endif
        .dir_o(dir1)
    );

    running_light_engine #(.WIDTH(8), .DIV(4), .RST_VAL(8'h3C)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .data_i(data_i),
        .load_val(load_val), .light(light4), .step_o(step4),
`ifdef RUNNING_LIGHT_SOUT_EN
        .data_o(dout4),
`endif
        .dir_o(dir4)
    );

`ifndef RUNNING_LIGHT_SOUT_EN
    assign dout1 = 1'b0;
    assign dout4 = 1'b0;
`endif

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] light;
        logic       step;
        logic       dir;
        logic       chk_do;
        logic       dout;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation due for the current cycle and compares.
    exp_t       e_m;
    logic [7:0] a_l;
    logic       a_s, a_d, a_o, ok;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e_m = q.pop_front();
            a_l = (e_m.sel == 0) ? light1 : light4;
            a_s = (e_m.sel == 0) ? step1 : step4;
            a_d = (e_m.sel == 0) ? dir1 : dir4;
            a_o = (e_m.sel == 0) ? dout1 : dout4;
            ok  = (a_l === e_m.light) && (a_s === e_m.step) && (a_d === e_m.dir);
`ifdef RUNNING_LIGHT_SOUT_EN
            if (e_m.chk_do) ok = ok && (a_o === e_m.dout);
`endif
            n_chk++;
            if (ok) n_pass++;
            else $display("FAIL %s (div%0d): got light=%h step=%b dir=%b do=%b, expected light=%h step=%b dir=%b do=%b",
                          e_m.name, (e_m.sel == 0) ? 1 : 4, a_l, a_s, a_d, a_o,
                          e_m.light, e_m.step, e_m.dir, e_m.dout);
        end
    end

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic drv(input logic r, input logic e, input logic [2:0] m,
                       input logic di, input logic [7:0] lv, input int sel,
                       input logic [7:0] el, input logic es, input logic ed,
                       input logic cd, input logic edo, input string nm);
        exp_t x;
        @(negedge clk);
        #1;
        rst = r; en = e; mode = m; data_i = di; load_val = lv;
        x.cyc = cyc + 1; x.sel = sel; x.light = el; x.step = es; x.dir = ed;
        x.chk_do = cd; x.dout = edo; x.name = nm;
        q.push_back(x);
    endtask

    initial begin
        // Reset with a running SHR request, then release.
        drv(0, 1, 1, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, "reset1");
        drv(0, 1, 1, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, "reset2");
        drv(1, 1, 1, 1, 8'h00, 0, 8'h80, 1, 0, 0, 0, "first_step");
        // SHR
        drv(1, 1, 6, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, "load00");
        drv(1, 1, 1, 1, 8'h00, 0, 8'h80, 1, 0, 0, 0, "shr1");
        drv(1, 1, 1, 1, 8'h00, 0, 8'hC0, 1, 0, 0, 0, "shr2");
        drv(1, 1, 1, 1, 8'h00, 0, 8'hE0, 1, 0, 0, 0, "shr3");
        // ROL / ROR / SHL / HOLD / reserved
        drv(1, 1, 6, 0, 8'h81, 0, 8'h81, 0, 0, 0, 0, "load81");
        drv(1, 1, 4, 0, 8'h00, 0, 8'h03, 1, 0, 0, 0, "rol1");
        drv(1, 1, 4, 0, 8'h00, 0, 8'h06, 1, 0, 0, 0, "rol2");
        drv(1, 1, 6, 0, 8'h81, 0, 8'h81, 0, 0, 0, 0, "reload81");
        drv(1, 1, 3, 0, 8'h00, 0, 8'hC0, 1, 0, 0, 0, "ror1");
        drv(1, 1, 3, 0, 8'h00, 0, 8'h60, 1, 0, 0, 0, "ror2");
        drv(1, 1, 2, 0, 8'h00, 0, 8'hC0, 1, 0, 0, 0, "shl0");
        drv(1, 1, 2, 1, 8'h00, 0, 8'h81, 1, 0, 0, 0, "shl1");
        drv(1, 1, 0, 1, 8'h00, 0, 8'h81, 1, 0, 0, 0, "hold");
        drv(1, 1, 7, 1, 8'h00, 0, 8'h81, 1, 0, 0, 0, "reserved");
        // BOUNCE
        drv(1, 1, 6, 0, 8'h02, 0, 8'h02, 0, 0, 0, 0, "load02");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h01, 1, 0, 0, 0, "bnc_01");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h02, 1, 1, 0, 0, "bnc_turnL");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h04, 1, 1, 0, 0, "bnc_04");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h08, 1, 1, 0, 0, "bnc_08");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h10, 1, 1, 0, 0, "bnc_10");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h20, 1, 1, 0, 0, "bnc_20");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h40, 1, 1, 0, 0, "bnc_40");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h80, 1, 1, 0, 0, "bnc_80");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h40, 1, 0, 0, 0, "bnc_turnR");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h20, 1, 0, 0, 0, "bnc_20r");
        drv(1, 1, 6, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, "bnc_load0");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, "bnc_zero1");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, "bnc_zero2");
        // dir_o holds outside BOUNCE; en = 0 suppresses steps
        drv(1, 1, 6, 0, 8'h02, 0, 8'h02, 0, 0, 0, 0, "load02b");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h01, 1, 0, 0, 0, "bnc_b1");
        drv(1, 1, 5, 0, 8'h00, 0, 8'h02, 1, 1, 0, 0, "bnc_b2");
        drv(1, 1, 1, 0, 8'h00, 0, 8'h01, 1, 1, 0, 0, "shr_keepdir");
        drv(1, 0, 1, 1, 8'h00, 0, 8'h01, 0, 1, 0, 0, "en_off");
        // Shifted-out bit (checked only when data_o exists)
        drv(1, 1, 6, 0, 8'h01, 0, 8'h01, 0, 0, 1, 0, "do_load01");
        drv(1, 1, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 1, "do_shr");
        drv(1, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 1, 1, "do_hold");
        drv(1, 1, 6, 0, 8'h80, 0, 8'h80, 0, 0, 1, 0, "do_load80");
        drv(1, 1, 2, 0, 8'h00, 0, 8'h00, 1, 0, 1, 1, "do_shl");

        // DIV = 4 instance
        drv(1, 1, 6, 0, 8'h01, 1, 8'h01, 0, 0, 0, 0, "p_load01");
        for (int i = 0; i < 3; i++) drv(1, 1, 3, 0, 8'h00, 1, 8'h01, 0, 0, 0, 0, "p_wait");
        drv(1, 1, 3, 0, 8'h00, 1, 8'h80, 1, 0, 0, 0, "p_step4");
        drv(1, 1, 3, 0, 8'h00, 1, 8'h80, 0, 0, 0, 0, "p_pulse_end");
        drv(1, 1, 3, 0, 8'h00, 1, 8'h80, 0, 0, 0, 0, "p_cnt2");
        drv(1, 0, 3, 0, 8'h00, 1, 8'h80, 0, 0, 0, 0, "p_freeze1");
        drv(1, 0, 3, 0, 8'h00, 1, 8'h80, 0, 0, 0, 0, "p_freeze2");
        drv(1, 1, 3, 0, 8'h00, 1, 8'h80, 0, 0, 0, 0, "p_cnt3");
        drv(1, 1, 3, 0, 8'h00, 1, 8'h40, 1, 0, 0, 0, "p_delayed");
        // Load mid-bounce at count 2
        drv(1, 1, 6, 0, 8'h02, 1, 8'h02, 0, 0, 0, 0, "p_load02");
        for (int i = 0; i < 3; i++) drv(1, 1, 5, 0, 8'h00, 1, 8'h02, 0, 0, 0, 0, "p_bw1");
        drv(1, 1, 5, 0, 8'h00, 1, 8'h01, 1, 0, 0, 0, "p_bnc1");
        for (int i = 0; i < 3; i++) drv(1, 1, 5, 0, 8'h00, 1, 8'h01, 0, 0, 0, 0, "p_bw2");
        drv(1, 1, 5, 0, 8'h00, 1, 8'h02, 1, 1, 0, 0, "p_bnc2");
        drv(1, 1, 5, 0, 8'h00, 1, 8'h02, 0, 1, 0, 0, "p_bw3a");
        drv(1, 1, 5, 0, 8'h00, 1, 8'h02, 0, 1, 0, 0, "p_bw3b");
        drv(1, 1, 6, 0, 8'hA5, 1, 8'hA5, 0, 0, 0, 0, "p_loadA5");
        for (int i = 0; i < 3; i++) drv(1, 1, 5, 0, 8'h00, 1, 8'hA5, 0, 0, 0, 0, "p_clr_wait");
        drv(1, 1, 5, 0, 8'h00, 1, 8'h4A, 1, 1, 0, 0, "p_bncA5");
        // Reset mid-operation, then restart from RST_VAL
        drv(0, 1, 1, 1, 8'h00, 1, 8'h3C, 0, 0, 0, 0, "p_reset");
        for (int i = 0; i < 3; i++) drv(1, 1, 1, 1, 8'h00, 1, 8'h3C, 0, 0, 0, 0, "p_rwait");
        drv(1, 1, 1, 1, 8'h00, 1, 8'h9E, 1, 0, 0, 0, "p_rstep");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
